// File: rtl/axi_lite_arbiter_if.sv
// AXI-lite bundle shared by both upstream masters and the downstream slave.
// The master modport is the side that issues requests; the slave modport answers them.
interface axi_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;

  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;

  logic       b_valid;
  logic       b_ready;
  logic [1:0] b_resp;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr,
           w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready,
           b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr,
           w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready,
           b_valid, b_resp
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-lite arbiter: m0 (instruction fetch, read only) and m1
// (load/store, read and write) share one downstream slave port. One
// transaction is in flight at a time; ties are broken round-robin.
//
// state | meaning
// IDLE  | no owner; arbitrate, nothing forwarded
// RD    | read owned by `owner`; AR forwarded until accepted, R passed back
// WR    | write owned by m1; AW and W forwarded until each accepted, B passed back
module axi_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t state;
  logic   owner;       // 0 = m0, 1 = m1
  logic   last_grant;  // master that won the most recent grant
  logic   ar_done;
  logic   aw_done;
  logic   w_done;

  logic              req_m0;
  logic              req_m1;
  logic              grant_m1;
  logic              sel_ar_valid;
  logic [ADDR_W-1:0] sel_ar_addr;
  logic              sel_r_ready;
  logic [DATA_W-1:0] r_data_zero;
  logic              unused_m0;

  // m0 only fetches instructions; its write-side request lines are ignored.
  assign unused_m0 = ^{m0.aw_valid, m0.aw_addr, m0.w_valid, m0.w_data,
                       m0.w_strb, m0.b_ready};

  // A pending m1 read outranks a pending m1 write; ties between masters go
  // to whichever did not win last time.
  assign req_m0   = m0.ar_valid;
  assign req_m1   = m1.ar_valid | m1.aw_valid;
  assign grant_m1 = req_m1 & (~req_m0 | ~last_grant);

  assign sel_ar_valid = owner ? m1.ar_valid : m0.ar_valid;
  assign sel_ar_addr  = owner ? m1.ar_addr  : m0.ar_addr;
  assign sel_r_ready  = owner ? m1.r_ready  : m0.r_ready;
  assign r_data_zero  = '0;

  // Arbitration state, ownership and per-channel "already accepted" flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_m0 | req_m1) begin
            owner      <= grant_m1;
            last_grant <= grant_m1;
            state      <= (grant_m1 & ~m1.ar_valid) ? WR : RD;
          end
        end
        RD: begin
          if (s.ar_valid & s.ar_ready) ar_done <= 1'b1;
          if (s.r_valid & s.r_ready) begin
            state   <= IDLE;
            ar_done <= 1'b0;
          end
        end
        WR: begin
          if (s.aw_valid & s.aw_ready) aw_done <= 1'b1;
          if (s.w_valid & s.w_ready)   w_done  <= 1'b1;
          if (s.b_valid & s.b_ready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Steer the owner's channels to the slave; everything else held at zero.
  always_comb begin
    s.ar_valid = 1'b0;
    s.ar_addr  = '0;
    s.r_ready  = 1'b0;
    s.aw_valid = 1'b0;
    s.aw_addr  = '0;
    s.w_valid  = 1'b0;
    s.w_data   = '0;
    s.w_strb   = '0;
    s.b_ready  = 1'b0;

    m0.ar_ready = 1'b0;
    m0.r_valid  = 1'b0;
    m0.r_data   = r_data_zero;
    m0.r_resp   = 2'b00;
    m0.aw_ready = 1'b0;
    m0.w_ready  = 1'b0;
    m0.b_valid  = 1'b0;
    m0.b_resp   = 2'b00;

    m1.ar_ready = 1'b0;
    m1.r_valid  = 1'b0;
    m1.r_data   = r_data_zero;
    m1.r_resp   = 2'b00;
    m1.aw_ready = 1'b0;
    m1.w_ready  = 1'b0;
    m1.b_valid  = 1'b0;
    m1.b_resp   = 2'b00;

    case (state)
      RD: begin
        s.ar_valid = sel_ar_valid & ~ar_done;
        s.ar_addr  = sel_ar_addr;
        s.r_ready  = sel_r_ready;
        if (owner) begin
          m1.ar_ready = s.ar_ready & ~ar_done;
          m1.r_valid  = s.r_valid;
          m1.r_data   = s.r_data;
          m1.r_resp   = s.r_resp;
        end else begin
          m0.ar_ready = s.ar_ready & ~ar_done;
          m0.r_valid  = s.r_valid;
          m0.r_data   = s.r_data;
          m0.r_resp   = s.r_resp;
        end
      end
      WR: begin
        s.aw_valid  = m1.aw_valid & ~aw_done;
        s.aw_addr   = m1.aw_addr;
        m1.aw_ready = s.aw_ready & ~aw_done;
        s.w_valid   = m1.w_valid & ~w_done;
        s.w_data    = m1.w_data;
        s.w_strb    = m1.w_strb;
        m1.w_ready  = s.w_ready & ~w_done;
        m1.b_valid  = s.b_valid;
        m1.b_resp   = s.b_resp;
        s.b_ready   = m1.b_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction-level model.
module tb_axi_lite_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  axi_lite_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .m0   (m0_bus),
    .m1   (m1_bus),
    .s    (s_bus)
  );

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: which transaction owns the slave (-1 none,
  // 0 m0 read, 1 m1 read, 2 m1 write), which request channels it has
  // already delivered, and who won the previous grant.
  int m_busy = -1;
  bit m_sent_ar = 0, m_sent_aw = 0, m_sent_w = 0;
  int m_last = 1;
  int grant_log[$];

  logic              e_s_ar_valid, e_s_r_ready, e_s_aw_valid, e_s_w_valid, e_s_b_ready;
  logic [ADDR_W-1:0] e_s_ar_addr, e_s_aw_addr;
  logic [DATA_W-1:0] e_s_w_data, e_m0_r_data, e_m1_r_data;
  logic [3:0]        e_s_w_strb;
  logic              e_m0_ar_ready, e_m0_r_valid, e_m1_ar_ready, e_m1_r_valid;
  logic [1:0]        e_m0_r_resp, e_m1_r_resp, e_m1_b_resp;
  logic              e_m1_aw_ready, e_m1_w_ready, e_m1_b_valid;
  logic              rq0, rq1r, rq1w;
  int                winner;

  // Compare every output against the model, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      {e_s_ar_valid, e_s_r_ready, e_s_aw_valid, e_s_w_valid, e_s_b_ready} = '0;
      e_s_ar_addr = '0; e_s_aw_addr = '0; e_s_w_data = '0; e_s_w_strb = '0;
      e_m0_ar_ready = 0; e_m0_r_valid = 0; e_m0_r_data = '0; e_m0_r_resp = '0;
      e_m1_ar_ready = 0; e_m1_r_valid = 0; e_m1_r_data = '0; e_m1_r_resp = '0;
      e_m1_aw_ready = 0; e_m1_w_ready = 0; e_m1_b_valid = 0; e_m1_b_resp = '0;

      if (m_busy == 0) begin
        e_s_ar_valid  = m0_bus.ar_valid && !m_sent_ar;
        e_s_ar_addr   = m0_bus.ar_addr;
        e_s_r_ready   = m0_bus.r_ready;
        e_m0_ar_ready = s_bus.ar_ready && !m_sent_ar;
        e_m0_r_valid  = s_bus.r_valid;
        e_m0_r_data   = s_bus.r_data;
        e_m0_r_resp   = s_bus.r_resp;
      end else if (m_busy == 1) begin
        e_s_ar_valid  = m1_bus.ar_valid && !m_sent_ar;
        e_s_ar_addr   = m1_bus.ar_addr;
        e_s_r_ready   = m1_bus.r_ready;
        e_m1_ar_ready = s_bus.ar_ready && !m_sent_ar;
        e_m1_r_valid  = s_bus.r_valid;
        e_m1_r_data   = s_bus.r_data;
        e_m1_r_resp   = s_bus.r_resp;
      end else if (m_busy == 2) begin
        e_s_aw_valid  = m1_bus.aw_valid && !m_sent_aw;
        e_s_aw_addr   = m1_bus.aw_addr;
        e_m1_aw_ready = s_bus.aw_ready && !m_sent_aw;
        e_s_w_valid   = m1_bus.w_valid && !m_sent_w;
        e_s_w_data    = m1_bus.w_data;
        e_s_w_strb    = m1_bus.w_strb;
        e_m1_w_ready  = s_bus.w_ready && !m_sent_w;
        e_m1_b_valid  = s_bus.b_valid;
        e_m1_b_resp   = s_bus.b_resp;
        e_s_b_ready   = m1_bus.b_ready;
      end

      check("s_ar_valid", s_bus.ar_valid, e_s_ar_valid);
      check("s_ar_addr", s_bus.ar_addr, e_s_ar_addr);
      check("s_r_ready", s_bus.r_ready, e_s_r_ready);
      check("s_aw_valid", s_bus.aw_valid, e_s_aw_valid);
      check("s_aw_addr", s_bus.aw_addr, e_s_aw_addr);
      check("s_w_valid", s_bus.w_valid, e_s_w_valid);
      check("s_w_data", s_bus.w_data, e_s_w_data);
      check("s_w_strb", s_bus.w_strb, e_s_w_strb);
      check("s_b_ready", s_bus.b_ready, e_s_b_ready);
      check("m0_ar_ready", m0_bus.ar_ready, e_m0_ar_ready);
      check("m0_r_valid", m0_bus.r_valid, e_m0_r_valid);
      check("m0_r_data", m0_bus.r_data, e_m0_r_data);
      check("m0_r_resp", m0_bus.r_resp, e_m0_r_resp);
      check("m0_wr_side", {m0_bus.aw_ready, m0_bus.w_ready, m0_bus.b_valid, m0_bus.b_resp}, 0);
      check("m1_ar_ready", m1_bus.ar_ready, e_m1_ar_ready);
      check("m1_r_valid", m1_bus.r_valid, e_m1_r_valid);
      check("m1_r_data", m1_bus.r_data, e_m1_r_data);
      check("m1_r_resp", m1_bus.r_resp, e_m1_r_resp);
      check("m1_aw_ready", m1_bus.aw_ready, e_m1_aw_ready);
      check("m1_w_ready", m1_bus.w_ready, e_m1_w_ready);
      check("m1_b_valid", m1_bus.b_valid, e_m1_b_valid);
      check("m1_b_resp", m1_bus.b_resp, e_m1_b_resp);

      if (rst) begin
        m_busy = -1; m_sent_ar = 0; m_sent_aw = 0; m_sent_w = 0; m_last = 1;
      end else if (m_busy == -1) begin
        rq0  = m0_bus.ar_valid;
        rq1r = m1_bus.ar_valid;
        rq1w = m1_bus.aw_valid;
        winner = -1;
        if (rq0 && (rq1r || rq1w)) winner = 1 - m_last;
        else if (rq0)              winner = 0;
        else if (rq1r || rq1w)     winner = 1;
        if (winner == 0) m_busy = 0;
        else if (winner == 1) m_busy = rq1r ? 1 : 2;
        if (winner >= 0) begin
          m_last = winner;
          grant_log.push_back(winner);
        end
      end else if (m_busy == 0 || m_busy == 1) begin
        if (e_s_ar_valid && s_bus.ar_ready) m_sent_ar = 1;
        if (s_bus.r_valid && e_s_r_ready) begin
          m_busy = -1; m_sent_ar = 0;
        end
      end else begin
        if (e_s_aw_valid && s_bus.aw_ready) m_sent_aw = 1;
        if (e_s_w_valid && s_bus.w_ready)   m_sent_w = 1;
        if (s_bus.b_valid && m1_bus.b_ready) begin
          m_busy = -1; m_sent_aw = 0; m_sent_w = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    m0_bus.ar_valid = 0; m0_bus.ar_addr = '0; m0_bus.r_ready = 0;
    m0_bus.aw_valid = 0; m0_bus.aw_addr = '0; m0_bus.w_valid = 0;
    m0_bus.w_data = '0; m0_bus.w_strb = '0; m0_bus.b_ready = 0;
    m1_bus.ar_valid = 0; m1_bus.ar_addr = '0; m1_bus.r_ready = 0;
    m1_bus.aw_valid = 0; m1_bus.aw_addr = '0; m1_bus.w_valid = 0;
    m1_bus.w_data = '0; m1_bus.w_strb = '0; m1_bus.b_ready = 0;
    s_bus.ar_ready = 0; s_bus.r_valid = 0; s_bus.r_data = '0; s_bus.r_resp = '0;
    s_bus.aw_ready = 0; s_bus.w_ready = 0; s_bus.b_valid = 0; s_bus.b_resp = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    grant_log.delete();
  endtask

  initial begin
    clear_inputs();
    reset_dut();
    chk_en = 1;

    // Reset state
    settle();
    check("rst_s_ar_valid", s_bus.ar_valid, 0);
    check("rst_m0_ar_ready", m0_bus.ar_ready, 0);
    check("rst_s_aw_w_valid", {s_bus.aw_valid, s_bus.w_valid}, 0);
    tick();

    // Single m0 read with data two cycles after the address
    m0_bus.ar_valid = 1; m0_bus.ar_addr = 32'h8000_0000; m0_bus.r_ready = 1;
    s_bus.ar_ready = 1;
    settle(); check("rd_idle_no_fwd", s_bus.ar_valid, 0);
    tick();
    settle();
    check("rd_s_ar_valid", s_bus.ar_valid, 1);
    check("rd_s_ar_addr", s_bus.ar_addr, 32'h8000_0000);
    check("rd_m0_ar_ready", m0_bus.ar_ready, 1);
    tick();
    m0_bus.ar_valid = 0; s_bus.ar_ready = 0;
    settle(); check("rd_wait_r_valid", m0_bus.r_valid, 0);
    tick();
    s_bus.r_valid = 1; s_bus.r_data = 32'hDEAD_BEEF;
    settle();
    check("rd_m0_r_valid", m0_bus.r_valid, 1);
    check("rd_m0_r_data", m0_bus.r_data, 32'hDEAD_BEEF);
    tick();
    s_bus.r_valid = 0;
    settle(); check("rd_back_idle", {s_bus.ar_valid, s_bus.r_ready}, 0);
    tick();

    // Simultaneous reads: m0, m1, then m0 again
    reset_dut();
    m0_bus.ar_valid = 1; m0_bus.ar_addr = 32'h1000; m0_bus.r_ready = 1;
    m1_bus.ar_valid = 1; m1_bus.ar_addr = 32'h2000; m1_bus.r_ready = 1;
    s_bus.ar_ready = 1; s_bus.r_valid = 1; s_bus.r_data = 32'h5555_AAAA;
    settle(); check("tie_idle0", s_bus.ar_valid, 0);
    tick();
    settle();
    check("tie_first_addr", s_bus.ar_addr, 32'h1000);
    check("tie_first_m1_ready", m1_bus.ar_ready, 0);
    tick();
    settle(); check("tie_gap_idle", s_bus.ar_valid, 0);
    tick();
    settle();
    check("tie_second_addr", s_bus.ar_addr, 32'h2000);
    check("tie_second_m0_ready", m0_bus.ar_ready, 0);
    tick();
    tick();
    settle(); check("tie_third_addr", s_bus.ar_addr, 32'h1000);
    tick();
    clear_inputs();
    check("tie_grant_count", grant_log.size(), 3);
    if (grant_log.size() >= 3) begin
      check("tie_grant0", grant_log[0], 0);
      check("tie_grant1", grant_log[1], 1);
      check("tie_grant2", grant_log[2], 0);
    end
    tick();

    // m1 write, slave takes W before AW
    reset_dut();
    m1_bus.aw_valid = 1; m1_bus.aw_addr = 32'h8000_0010;
    m1_bus.w_valid = 1; m1_bus.w_data = 32'h1234_5678; m1_bus.w_strb = 4'hF;
    m1_bus.b_ready = 1; s_bus.w_ready = 1;
    tick();
    settle();
    check("wr_aw_fwd", {s_bus.aw_valid, s_bus.aw_addr}, {1'b1, 32'h8000_0010});
    check("wr_w_fwd", {s_bus.w_valid, s_bus.w_data, s_bus.w_strb}, {1'b1, 32'h1234_5678, 4'hF});
    check("wr_m0_ready", m0_bus.ar_ready, 0);
    tick();
    s_bus.aw_ready = 1;
    settle();
    check("wr_w_once", s_bus.w_valid, 0);
    check("wr_aw_still", s_bus.aw_valid, 1);
    tick();
    s_bus.aw_ready = 0; s_bus.b_valid = 1; s_bus.b_resp = 2'b00;
    settle();
    check("wr_aw_once", s_bus.aw_valid, 0);
    check("wr_b", {m1_bus.b_valid, m1_bus.b_resp}, {1'b1, 2'b00});
    tick();
    clear_inputs();
    tick();

    // m0 read waits behind an m1 write with slow B
    reset_dut();
    m1_bus.aw_valid = 1; m1_bus.w_valid = 1; m1_bus.b_ready = 1;
    m1_bus.aw_addr = 32'h40; m1_bus.w_data = 32'h77; m1_bus.w_strb = 4'h3;
    s_bus.aw_ready = 1; s_bus.w_ready = 1;
    tick();
    m0_bus.ar_valid = 1; m0_bus.ar_addr = 32'h3000; s_bus.ar_ready = 1;
    for (int i = 0; i < 5; i++) begin
      settle(); check("blk_m0_ready", m0_bus.ar_ready, 0);
      tick();
      m1_bus.aw_valid = 0; m1_bus.w_valid = 0;
    end
    s_bus.b_valid = 1;
    settle(); check("blk_b_valid", m1_bus.b_valid, 1);
    tick();
    s_bus.b_valid = 0;
    settle(); check("blk_idle", {s_bus.ar_valid, m0_bus.ar_ready}, 0);
    tick();
    settle(); check("blk_m0_granted", {s_bus.ar_valid, s_bus.ar_addr, m0_bus.ar_ready}, {1'b1, 32'h3000, 1'b1});
    tick();
    m0_bus.ar_valid = 0; s_bus.r_valid = 1; m0_bus.r_ready = 1;
    tick();
    clear_inputs();
    tick();

    // Error response passes through untouched
    reset_dut();
    m1_bus.ar_valid = 1; m1_bus.ar_addr = 32'h4000; m1_bus.r_ready = 1;
    s_bus.ar_ready = 1; s_bus.r_valid = 1; s_bus.r_resp = 2'b10; s_bus.r_data = 32'h0BAD;
    tick();
    settle();
    check("err_m1_r_resp", m1_bus.r_resp, 2'b10);
    check("err_m0_r_valid", m0_bus.r_valid, 0);
    tick();
    clear_inputs();
    tick();

    // Reset in the middle of a read abandons it
    reset_dut();
    m0_bus.ar_valid = 1; m0_bus.ar_addr = 32'h5000; m0_bus.r_ready = 1; s_bus.ar_ready = 1;
    tick();
    tick();
    m0_bus.ar_valid = 0;
    rst = 1;
    tick();
    rst = 0; s_bus.r_valid = 1;
    settle();
    check("mid_rst_idle", {s_bus.ar_valid, s_bus.r_ready, m0_bus.r_valid, m0_bus.ar_ready}, 0);
    tick();
    clear_inputs();
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      m0_bus.ar_valid = ($urandom_range(0, 2) == 0);
      m0_bus.ar_addr  = $urandom;
      m0_bus.r_ready  = ($urandom_range(0, 3) != 0);
      m0_bus.aw_valid = $urandom_range(0, 1);
      m0_bus.aw_addr  = $urandom;
      m0_bus.w_valid  = $urandom_range(0, 1);
      m0_bus.w_data   = $urandom;
      m0_bus.w_strb   = 4'($urandom);
      m0_bus.b_ready  = $urandom_range(0, 1);
      m1_bus.ar_valid = ($urandom_range(0, 3) == 0);
      m1_bus.ar_addr  = $urandom;
      m1_bus.r_ready  = ($urandom_range(0, 3) != 0);
      m1_bus.aw_valid = ($urandom_range(0, 2) == 0);
      m1_bus.aw_addr  = $urandom;
      m1_bus.w_valid  = $urandom_range(0, 1);
      m1_bus.w_data   = $urandom;
      m1_bus.w_strb   = 4'($urandom);
      m1_bus.b_ready  = ($urandom_range(0, 3) != 0);
      s_bus.ar_ready  = $urandom_range(0, 1);
      s_bus.r_valid   = ($urandom_range(0, 2) == 0);
      s_bus.r_data    = $urandom;
      s_bus.r_resp    = 2'($urandom);
      s_bus.aw_ready  = $urandom_range(0, 1);
      s_bus.w_ready   = $urandom_range(0, 1);
      s_bus.b_valid   = ($urandom_range(0, 2) == 0);
      s_bus.b_resp    = 2'($urandom);
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
